// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its neighbours on the MAR/MDR path.
package mem_pkg;

    localparam int unsigned WORD_WIDTH          = 32;
    localparam int unsigned DEFAULT_WAIT_STATES = 2;
    localparam int unsigned WAIT_CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        READ,
        WRITE
    } op_t;

    // Exactly one strobe must be raised for a request to be accepted.
    function automatic logic is_legal_req(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between the CPU datapath (MAR/MDR/control) and the memory responder.
interface memory_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = WORD_WIDTH
);

    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] MDRout;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  done;
    logic                  busy;

    modport master (
        output address,
        output MDRout,
        output read,
        output write,
        input  Mdatain,
        input  done,
        input  busy
    );

    modport slave (
        input  address,
        input  MDRout,
        input  read,
        input  write,
        output Mdatain,
        output done,
        output busy
    );

endinterface

// File: rtl/ram_sync.sv
// Single-port synchronous RAM, registered read, write-first. No reset on contents or output.
module ram_sync #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side end of the MAR/MDR interface: services one read or write per request after
// WAIT_STATES wait cycles and pulses done for one cycle on completion.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DATA_WIDTH  = WORD_WIDTH,
    parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic          clock,
    input  logic          clear,
    memory_responder_if.slave bus
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WaitLoad =
        (WAIT_STATES > 0) ? WAIT_CNT_WIDTH'(WAIT_STATES - 1) : '0;

    state_t                    state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    op_t                       op_q, op_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     mdata_q, mdata_d;
    logic                      accept;
    logic                      ram_we;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    assign accept = (state_q == IDLE) && is_legal_req(bus.read, bus.write);

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = WaitLoad;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data holding register
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mdata_d = mdata_q;
        if (accept) begin
            op_d   = bus.write ? WRITE : READ;
            addr_d = bus.address;
            if (bus.write) begin
                data_d = bus.MDRout;
            end
        end
        if ((state_q == DONE) && (op_q == READ)) begin
            mdata_d = ram_rdata;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q    <= READ;
            addr_q  <= '0;
            data_q  <= '0;
            mdata_q <= '0;
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mdata_q <= mdata_d;
        end
    end

    // Outputs. The RAM's own output register is the read-data register during DONE, so
    // Mdatain takes the new word at the ACCESS edge; mdata_q holds it afterwards.
    always_comb begin
        ram_we      = (state_q == ACCESS) && (op_q == WRITE);
        bus.done    = (state_q == DONE);
        bus.busy    = (state_q != IDLE);
        bus.Mdatain = ((state_q == DONE) && (op_q == READ)) ? ram_rdata : mdata_q;
    end

    ram_sync #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

endmodule
